// File: rtl/rr_arb4_if.sv
// rr_arb4_if -- signal bundle between the round-robin arbiter, the 4:1 mux
// and the downstream consumer.
//
// Parameter:
//   WIDTH   data width, must match the mux width
//
// Handshake: a source n word is consumed in any cycle where req_i[n] & gnt_o[n];
// the registered output word is transferred in any cycle where
// valid_o & ready_i. valid_o never drops without a transfer or a reset.
//
// Signals:
//   req_i    4      per-source request
//   gnt_o    4      one-hot combinational grant
//   sel_o    2      mux select
//   mux_i    WIDTH  mux result
//   valid_o  1      registered output word valid
//   data_o   WIDTH  registered output word
//   src_o    2      source index of data_o
//   ready_i  1      downstream ready
//   count_o  16     accepted-transfer counter (only with RR_ARB4_CNT_EN)
//
// Modports: master = arbiter side, slave = environment side.
// Optional feature macro: RR_ARB4_CNT_EN
interface rr_arb4_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       req_i;
  logic [3:0]       gnt_o;
  logic [1:0]       sel_o;
  logic [WIDTH-1:0] mux_i;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic [1:0]       src_o;
  logic             ready_i;
`ifdef RR_ARB4_CNT_EN
  logic [15:0]      count_o;
`endif

  modport master (
    input  req_i, mux_i, ready_i,
    output gnt_o, sel_o, valid_o, data_o, src_o
`ifdef RR_ARB4_CNT_EN
    , output count_o
`endif
  );

  modport slave (
    output req_i, mux_i, ready_i,
    input  gnt_o, sel_o, valid_o, data_o, src_o
`ifdef RR_ARB4_CNT_EN
    , input count_o
`endif
  );
endinterface

// File: rtl/rr_arb4.sv
// rr_arb4 -- four-source round-robin arbiter with a registered,
// back-pressurable output stage for a 4:1 WIDTH-bit mux.
//
// Each cycle with a free (or draining) output slot, one requesting source is
// chosen round-robin starting after the last winner, the mux is steered to
// it via sel_o, and the mux result is captured together with the winner index.
//
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous active-high reset
//   bus     rr_arb4_if.master (req/gnt/sel/mux/valid/data/src/ready[/count])
//
// Optional feature macro: RR_ARB4_CNT_EN adds a saturating 16-bit counter of
// accepted transfers on bus.count_o.
module rr_arb4 #(
  parameter int WIDTH = 8
) (
  input  logic      clk_i,
  input  logic      rst_i,
  rr_arb4_if.master bus
);

  logic [1:0]       last_q;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       src_q;

  logic             cap;
  logic             found;
  logic             grant;
  logic [1:0]       win;

  // Slot is free, or its word leaves this cycle.
  assign cap = !valid_q | bus.ready_i;

  // First requester in the order last+1 .. last+4 (mod 4).
  always_comb begin
    logic [1:0] cand;
    win   = last_q;
    found = 1'b0;
    cand  = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && bus.req_i[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign grant = !rst_i && cap && found;

  always_comb begin
    bus.gnt_o = 4'b0000;
    bus.sel_o = last_q;
    if (rst_i) begin
      bus.sel_o = 2'b11;
    end else if (grant) begin
      bus.gnt_o = 4'b0001 << win;
      bus.sel_o = win;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= 2'd0;
      last_q  <= 2'd3;
    end else if (grant) begin
      // Capture also covers the drain-and-refill case: no bubble.
      valid_q <= 1'b1;
      data_q  <= bus.mux_i;
      src_q   <= win;
      last_q  <= win;
    end else if (bus.ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.src_o   = src_q;

`ifdef RR_ARB4_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 16'd0;
    end else if (valid_q && bus.ready_i && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.count_o = cnt_q;
`endif

endmodule

// File: tb/tb_rr_arb4.sv
module tb_rr_arb4;
  localparam int WIDTH = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_arb4_if #(.WIDTH(WIDTH)) bus ();

  rr_arb4 #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // The external 4:1 mux.
  logic [WIDTH-1:0] d [4];
  assign bus.mux_i = d[bus.sel_o];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: output slot plus last winner, as plain integers.
  bit               model_ok = 1'b0;
  int               m_last, m_valid, m_src, m_cnt;
  logic [WIDTH-1:0] m_data;

  always @(negedge clk) begin : cmp
    int win;
    int exp_gnt;
    int exp_sel;
    win     = -1;
    exp_gnt = 0;
    exp_sel = m_last;
    if (rst) begin
      exp_sel = 3;
    end else if ((m_valid == 0 || bus.ready_i) && bus.req_i != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        if (win < 0 && bus.req_i[(m_last + k) % 4]) win = (m_last + k) % 4;
      end
      exp_gnt = 1 << win;
      exp_sel = win;
    end
    if (model_ok) begin
      chk("m_gnt", 32'(bus.gnt_o), 32'(exp_gnt));
      chk("m_sel", 32'(bus.sel_o), 32'(exp_sel));
      chk("m_valid", 32'(bus.valid_o), 32'(m_valid));
      if (m_valid != 0) begin
        chk("m_data", 32'(bus.data_o), 32'(m_data));
        chk("m_src", 32'(bus.src_o), 32'(m_src));
      end
`ifdef RR_ARB4_CNT_EN
      chk("m_count", 32'(bus.count_o), 32'(m_cnt));
`endif
    end
    // state after the coming rising edge
    if (rst) begin
      m_valid  = 0;
      m_data   = '0;
      m_src    = 0;
      m_last   = 3;
      m_cnt    = 0;
      model_ok = 1'b1;
    end else begin
      if (m_valid != 0 && bus.ready_i && m_cnt < 65535) m_cnt++;
      if (win >= 0) begin
        m_valid = 1;
        m_data  = d[win];
        m_src   = win;
        m_last  = win;
      end else if (bus.ready_i) begin
        m_valid = 0;
      end
    end
  end

  // driver: apply inputs just after a rising edge, return after the falling edge
  task automatic cyc(input logic [3:0] r, input logic rdy, input logic rs);
    @(posedge clk);
    #1;
    bus.req_i   = r;
    bus.ready_i = rdy;
    rst         = rs;
    @(negedge clk);
    #1;
  endtask

  task automatic rcyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) d[i] = WIDTH'($urandom_range(0, 255));
    bus.req_i   = 4'($urandom_range(0, 15));
    bus.ready_i = ($urandom_range(0, 3) != 0);
    rst         = ($urandom_range(0, 30) == 0);
    @(negedge clk);
    #1;
  endtask

  logic [3:0] rr_gnt [6];
  logic [7:0] rr_data [5];

  initial begin
    bus.req_i   = 4'b0000;
    bus.ready_i = 1'b0;
    d[0] = 8'h10; d[1] = 8'h20; d[2] = 8'h30; d[3] = 8'h40;
    rr_gnt[0] = 4'b0001; rr_gnt[1] = 4'b0010; rr_gnt[2] = 4'b0100;
    rr_gnt[3] = 4'b1000; rr_gnt[4] = 4'b0001; rr_gnt[5] = 4'b0010;
    rr_data[0] = 8'h10; rr_data[1] = 8'h20; rr_data[2] = 8'h30;
    rr_data[3] = 8'h40; rr_data[4] = 8'h10;

    // reset then idle
    cyc(4'b0000, 1'b1, 1'b1);
    chk("rst_gnt", 32'(bus.gnt_o), 32'h0);
    chk("rst_sel", 32'(bus.sel_o), 32'h3);
    cyc(4'b0000, 1'b1, 1'b1);
    cyc(4'b0000, 1'b1, 1'b0);
    chk("idle_valid", 32'(bus.valid_o), 32'h0);
    chk("idle_gnt", 32'(bus.gnt_o), 32'h0);
    chk("idle_sel", 32'(bus.sel_o), 32'h3);
    chk("idle_data", 32'(bus.data_o), 32'h0);

    // all four requesting: 0,1,2,3,0,1
    for (int i = 0; i < 6; i++) begin
      cyc(4'b1111, 1'b1, 1'b0);
      chk("rr_gnt", 32'(bus.gnt_o), 32'(rr_gnt[i]));
      if (i > 0) begin
        chk("rr_data", 32'(bus.data_o), 32'(rr_data[i-1]));
        chk("rr_src", 32'(bus.src_o), 32'((i - 1) % 4));
      end
    end

    // backpressure while holding 8'h20
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1111, 1'b0, 1'b0);
      chk("bp_gnt", 32'(bus.gnt_o), 32'h0);
      chk("bp_valid", 32'(bus.valid_o), 32'h1);
      chk("bp_data", 32'(bus.data_o), 32'h20);
      chk("bp_src", 32'(bus.src_o), 32'h1);
    end
    cyc(4'b1111, 1'b1, 1'b0);
    chk("bp_release_gnt", 32'(bus.gnt_o), 32'b0100);
    chk("bp_release_sel", 32'(bus.sel_o), 32'h2);

    // sparse requests: last=2 -> 0, then 3,0,3
    cyc(4'b0001, 1'b1, 1'b0);
    chk("sp_gnt0", 32'(bus.gnt_o), 32'b0001);
    cyc(4'b1001, 1'b1, 1'b0);
    chk("sp_gnt3", 32'(bus.gnt_o), 32'b1000);
    chk("sp_data0", 32'(bus.data_o), 32'h10);
    cyc(4'b1001, 1'b1, 1'b0);
    chk("sp_gnt0b", 32'(bus.gnt_o), 32'b0001);
    chk("sp_data3", 32'(bus.data_o), 32'h40);
    chk("sp_src3", 32'(bus.src_o), 32'h3);
    cyc(4'b1001, 1'b1, 1'b0);
    chk("sp_gnt3b", 32'(bus.gnt_o), 32'b1000);

    // reset mid-stream
    cyc(4'b1001, 1'b1, 1'b1);
    chk("mr_gnt", 32'(bus.gnt_o), 32'h0);
    chk("mr_sel", 32'(bus.sel_o), 32'h3);
    chk("mr_valid_before", 32'(bus.valid_o), 32'h1);
    cyc(4'b0110, 1'b1, 1'b0);
    chk("mr_valid_after", 32'(bus.valid_o), 32'h0);
    chk("mr_gnt_lowest", 32'(bus.gnt_o), 32'b0010);
    cyc(4'b0000, 1'b1, 1'b0);
    chk("mr_data", 32'(bus.data_o), 32'h20);
    chk("mr_src", 32'(bus.src_o), 32'h1);
    chk("mr_sel_hold", 32'(bus.sel_o), 32'h1);
    cyc(4'b0000, 1'b1, 1'b0);
    chk("drain_valid", 32'(bus.valid_o), 32'h0);

`ifdef RR_ARB4_CNT_EN
    cyc(4'b0001, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cyc(4'b0001, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("cnt_five", 32'(bus.count_o), 32'd5);
    for (int i = 0; i < 65540; i++) cyc(4'b0001, 1'b1, 1'b0);
    chk("cnt_sat", 32'(bus.count_o), 32'hFFFF);
`endif

    // mixed traffic checked by the model
    for (int i = 0; i < 200; i++) rcyc();
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
